// File: rtl/calc_pkg.sv
// Shared key codes, operation encoding and entry-FSM states for the calculator keypad front end.
package calc_pkg;

    localparam logic [3:0] KEY_ADD = 4'hA;
    localparam logic [3:0] KEY_SUB = 4'hB;
    localparam logic [3:0] KEY_CLR = 4'hC;
    localparam logic [3:0] KEY_EQ  = 4'hE;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic is_digit_key(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/bcd_digit_shift_reg.sv
// One packed-BCD operand plus its entered-digit count; digits shift in from the least significant end.
module bcd_digit_shift_reg #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                shift_en,
    input  logic [3:0]          digit,
    input  logic                clr,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    output logic [4*DIGITS-1:0] value,
    output logic                full
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);

    logic [CW-1:0] count;

    assign full = (count == CW'(DIGITS));

    // clr together with shift_en starts a fresh operand holding just that digit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
            count <= '0;
        end else if (clr) begin
            value <= shift_en ? W'(digit) : '0;
            count <= shift_en ? CW'(1) : '0;
        end else if (load) begin
            value <= load_val;
            count <= CW'(DIGITS);
        end else if (shift_en && !full) begin
            value <= {value[W-5:0], digit};
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/bcd_operand_entry.sv
// Keypad front end: builds operands A/B from key strokes and strobes go to alu_BCD.
// Optional feature macro: CHAIN_RESULT_EN (add/sub after a result continues from alu_result).
module bcd_operand_entry
    import calc_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                key_valid,
    input  logic [3:0]          key_code,
    input  logic [4*DIGITS-1:0] alu_result,
    input  logic                alu_valid,
    output logic [4*DIGITS-1:0] a,
    output logic [4*DIGITS-1:0] b,
    output logic                op,
    output logic                go,
    output logic [4*DIGITS-1:0] display,
    output logic                entry_err
);

    localparam int W = 4 * DIGITS;

    state_t        state, state_nxt;
    logic          op_nxt, go_nxt, err_nxt;
    logic          a_shift, a_clr, a_load, a_full;
    logic          b_shift, b_clr, b_full;
    logic [W-1:0]  a_load_val;
    logic          is_arith;

    bcd_digit_shift_reg #(.DIGITS(DIGITS)) u_reg_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (a_shift),
        .digit    (key_code),
        .clr      (a_clr),
        .load     (a_load),
        .load_val (a_load_val),
        .value    (a),
        .full     (a_full)
    );

    bcd_digit_shift_reg #(.DIGITS(DIGITS)) u_reg_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (b_shift),
        .digit    (key_code),
        .clr      (b_clr),
        .load     (1'b0),
        .load_val ('0),
        .value    (b),
        .full     (b_full)
    );

`ifndef CHAIN_RESULT_EN
    logic unused_alu_valid;
    assign unused_alu_valid = alu_valid;
`endif

    assign is_arith = (key_code == KEY_ADD) || (key_code == KEY_SUB);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_A;
            op        <= OP_ADD;
            go        <= 1'b0;
            entry_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            op        <= op_nxt;
            go        <= go_nxt;
            entry_err <= err_nxt;
        end
    end

    // Key decode: every key acts on the operand registers and pulses in the same edge
    always_comb begin
        state_nxt  = state;
        op_nxt     = op;
        go_nxt     = 1'b0;
        err_nxt    = 1'b0;
        a_shift    = 1'b0;
        a_clr      = 1'b0;
        a_load     = 1'b0;
        a_load_val = '0;
        b_shift    = 1'b0;
        b_clr      = 1'b0;

        if (key_valid) begin
            if (key_code == KEY_CLR) begin
                a_clr     = 1'b1;
                b_clr     = 1'b1;
                op_nxt    = OP_ADD;
                state_nxt = S_A;
            end else begin
                unique case (state)
                    S_A: begin
                        if (is_digit_key(key_code)) begin
                            if (a_full) err_nxt = 1'b1;
                            else        a_shift = 1'b1;
                        end else if (is_arith) begin
                            op_nxt    = (key_code == KEY_SUB) ? OP_SUB : OP_ADD;
                            b_clr     = 1'b1;
                            state_nxt = S_B;
                        end
                    end
                    S_B: begin
                        if (is_digit_key(key_code)) begin
                            if (b_full) err_nxt = 1'b1;
                            else        b_shift = 1'b1;
                        end else if (is_arith) begin
                            op_nxt = (key_code == KEY_SUB) ? OP_SUB : OP_ADD;
                        end else if (key_code == KEY_EQ) begin
                            go_nxt    = 1'b1;
                            state_nxt = S_DONE;
                        end
                    end
                    S_DONE: begin
                        if (is_digit_key(key_code)) begin
                            a_clr     = 1'b1;
                            a_shift   = 1'b1;
                            b_clr     = 1'b1;
                            state_nxt = S_A;
                        end else if (key_code == KEY_EQ) begin
                            go_nxt = 1'b1;
                        end else if (is_arith) begin
                            op_nxt    = (key_code == KEY_SUB) ? OP_SUB : OP_ADD;
                            b_clr     = 1'b1;
                            state_nxt = S_B;
`ifdef CHAIN_RESULT_EN
                            a_load     = 1'b1;
                            a_load_val = alu_valid ? alu_result : '0;
                            err_nxt    = !alu_valid;
`endif
                        end
                    end
                    default: state_nxt = S_A;
                endcase
            end
        end
    end

    always_comb begin
        display = a;
        unique case (state)
            S_B:     display = b;
            S_DONE:  display = alu_result;
            default: display = a;
        endcase
    end

endmodule
